// File: rtl/timer_device_pkg.sv
// ---------------------------------------------------------------------------
// timer_device_pkg
//
// Shared CPU-side definitions for the programmable interval timer. The bus
// bridge imports this package too, so its address decode and the timer agree
// on register offsets, MODE values and the controller state encoding.
//
// Contents:
//   timer_state_e  - controller states (IDLE, LOAD, CNT, INT)
//   OFF_*          - word offsets of the timer registers
//   MODE_*         - CTRL.MODE field values
//   ctrl_t         - layout of the 4-bit CTRL register
// ---------------------------------------------------------------------------
package timer_device_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } timer_state_e;

    // Register word offsets.
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_RSVD   = 2'd3;

    // CTRL.MODE values; 2'b10 and 2'b11 behave as one-shot.
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_AUTO    = 2'b01;

    // CTRL register: [3] IM, [2:1] MODE, [0] EN.
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

endpackage

// File: rtl/timer_device.sv
// ---------------------------------------------------------------------------
// timer_device
//
// Programmable down-counting interval timer with a three-register bus view.
// Writing CTRL with EN=1 loads PRESET into COUNT and counts down to zero,
// then raises an interrupt flag. One-shot mode clears EN and holds the flag
// until software rewrites CTRL; auto-reload mode emits a one-cycle flag pulse
// and restarts the count from PRESET.
//
// Ports:
//   clk    in   1  system clock, all state updates on the rising edge
//   reset  in   1  synchronous active-high reset
//   addr   in   2  word offset: 0=CTRL, 1=PRESET, 2=COUNT (read-only), 3=reserved
//   we     in   1  write strobe, sampled on the rising edge
//   din    in  32  write data
//   dout   out 32  read data, combinational from addr
//   irq    out  1  interrupt request = CTRL.IM & internal flag
// ---------------------------------------------------------------------------
module timer_device
    import timer_device_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    timer_state_e state;
    timer_state_e state_next;

    ctrl_t       ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;

    logic ctrl_write;
    logic preset_write;

    // Controller actions decoded from the current state.
    logic cnt_load;
    logic cnt_dec;
    logic cnt_zero;
    logic flag_set;
    logic flag_clr;
    logic en_clr;

    assign ctrl_write   = we && (addr == OFF_CTRL);
    assign preset_write = we && (addr == OFF_PRESET);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: reset is sampled on the clock edge only (synchronous), and all
    // clocked state uses non-blocking assignments so every register sees the
    // pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and controller actions. Decisions use the register values
    // before any same-edge bus write takes effect.
    // -----------------------------------------------------------------------
    // NOTE: every output of this block is given a default first so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        cnt_zero   = 1'b0;
        flag_set   = 1'b0;
        flag_clr   = 1'b0;
        en_clr     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (ctrl.en) begin
                    state_next = ST_LOAD;
                end
            end

            ST_LOAD: begin
                cnt_load   = 1'b1;
                state_next = ST_CNT;
            end

            ST_CNT: begin
                if (!ctrl.en) begin
                    state_next = ST_IDLE;
                end else if (count > 32'd1) begin
                    cnt_dec = 1'b1;
                end else begin
                    // Covers COUNT of 1 and of 0, so a zero PRESET expires
                    // like a PRESET of 1 and COUNT never wraps.
                    cnt_zero   = 1'b1;
                    flag_set   = 1'b1;
                    state_next = ST_INT;
                end
            end

            ST_INT: begin
                state_next = ST_IDLE;
                if (ctrl.mode == MODE_AUTO) begin
                    // EN stays set, so IDLE immediately restarts the count.
                    flag_clr = 1'b1;
                end else begin
                    en_clr = 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers. A CTRL write wins over the controller's EN clear and its
    // flag set/clear on the same edge.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            if (ctrl_write) begin
                ctrl     <= ctrl_t'(din[3:0]);
                irq_flag <= 1'b0;
            end else begin
                if (en_clr) begin
                    ctrl.en <= 1'b0;
                end
                if (flag_set) begin
                    irq_flag <= 1'b1;
                end else if (flag_clr) begin
                    irq_flag <= 1'b0;
                end
            end

            // A new PRESET only matters at the next LOAD; the running count
            // is untouched.
            if (preset_write) begin
                preset <= din;
            end

            if (cnt_load) begin
                count <= preset;
            end else if (cnt_dec) begin
                count <= count - 32'd1;
            end else if (cnt_zero) begin
                count <= '0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read mux and interrupt output
    // -----------------------------------------------------------------------
    always_comb begin
        dout = '0;
        case (addr)
            OFF_CTRL:   dout = {28'd0, ctrl};
            OFF_PRESET: dout = preset;
            OFF_COUNT:  dout = count;
            OFF_RSVD:   dout = '0;
            default:    dout = '0;
        endcase
    end

    assign irq = ctrl.im & irq_flag;

endmodule

// File: tb/tb_timer_device.sv
// ---------------------------------------------------------------------------
// tb_timer_device
//
// Directed scenarios for one-shot, auto-reload, masking, disable mid-count,
// zero PRESET, reset and read-only/reserved writes, followed by randomized
// trials checked cycle by cycle against a closed-form timing model.
// ---------------------------------------------------------------------------
module tb_timer_device;
    import timer_device_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    timer_device dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .din   (din),
        .dout  (dout),
        .irq   (irq)
    );

    // Advance n rising edges; returns on the following falling edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive a write that lands on the next rising edge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        addr = a;
        din  = d;
        we   = 1'b1;
        tick(1);
        we   = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = dout;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus_read(a, v);
        check(tag, v, exp);
    endtask

    task automatic check_irq(input string tag, input logic exp);
        check(tag, {31'd0, irq}, {31'd0, exp});
    endtask

    initial begin
        int          p;
        int          pm;
        int          n;
        int          dp;
        int          junk_d;
        int          exp_count;
        bit          auto_mode;
        bit          exp_flag;
        logic [1:0]  mode;
        logic        im;
        logic [3:0]  ctrl_w;
        logic [3:0]  exp_ctrl;

        reset = 1'b1;
        we    = 1'b0;
        addr  = OFF_CTRL;
        din   = '0;
        @(negedge clk);
        tick(2);
        reset = 1'b0;

        // ---- reset state ----
        check_reg("rst_ctrl", OFF_CTRL, 32'h0);
        check_reg("rst_preset", OFF_PRESET, 32'h0);
        check_reg("rst_count", OFF_COUNT, 32'h0);
        check_reg("rst_rsvd", OFF_RSVD, 32'h0);
        check_irq("rst_irq", 1'b0);

        // ---- one-shot, PRESET=5: flag at E0+7, held ----
        bus_write(OFF_PRESET, 32'd5);
        bus_write(OFF_CTRL, 32'h9);
        tick(6);
        check_irq("os_irq_before", 1'b0);
        check_reg("os_count_1", OFF_COUNT, 32'd1);
        tick(1);
        check_irq("os_irq_rise", 1'b1);
        check_reg("os_count_0", OFF_COUNT, 32'd0);
        tick(1);
        check_reg("os_ctrl_en_clr", OFF_CTRL, 32'h8);
        check_irq("os_irq_held1", 1'b1);
        tick(4);
        check_irq("os_irq_held2", 1'b1);
        check_reg("os_count_hold", OFF_COUNT, 32'd0);
        bus_write(OFF_CTRL, 32'h0);
        check_irq("os_irq_cleared", 1'b0);

        // ---- auto-reload, PRESET=5: pulses at E0+7, +15, +23 ----
        bus_write(OFF_CTRL, 32'hB);
        for (int k = 0; k < 3; k++) begin
            tick(6);
            check_irq($sformatf("ar_low_%0d", k), 1'b0);
            tick(1);
            check_irq($sformatf("ar_pulse_%0d", k), 1'b1);
            tick(1);
            check_irq($sformatf("ar_drop_%0d", k), 1'b0);
            check_reg($sformatf("ar_ctrl_%0d", k), OFF_CTRL, 32'hB);
        end
        bus_write(OFF_CTRL, 32'h0);
        tick(3);

        // ---- masked, PRESET=3 ----
        bus_write(OFF_PRESET, 32'd3);
        bus_write(OFF_CTRL, 32'h1);
        tick(5);
        check_irq("mask_irq_at_flag", 1'b0);
        check_reg("mask_count", OFF_COUNT, 32'd0);
        tick(1);
        check_reg("mask_en_clr", OFF_CTRL, 32'h0);
        bus_write(OFF_CTRL, 32'h8);
        check_irq("mask_irq_after_im", 1'b0);
        check_reg("mask_ctrl", OFF_CTRL, 32'h8);
        tick(2);
        check_irq("mask_irq_later", 1'b0);

        // ---- disable mid-count, PRESET=10 ----
        bus_write(OFF_CTRL, 32'h0);
        bus_write(OFF_PRESET, 32'd10);
        bus_write(OFF_CTRL, 32'h1);
        tick(6);
        check_reg("dis_count_6", OFF_COUNT, 32'd6);
        bus_write(OFF_CTRL, 32'h0);
        check_reg("dis_count_5", OFF_COUNT, 32'd5);
        tick(4);
        check_reg("dis_count_frozen", OFF_COUNT, 32'd5);
        check_irq("dis_irq", 1'b0);
        check_reg("dis_ctrl", OFF_CTRL, 32'h0);
        // Re-enabling must go through LOAD again, proving the block sat in IDLE.
        bus_write(OFF_CTRL, 32'h1);
        tick(1);
        check_reg("dis_reen_hold", OFF_COUNT, 32'd5);
        tick(1);
        check_reg("dis_reen_load", OFF_COUNT, 32'd10);
        bus_write(OFF_CTRL, 32'h0);
        tick(2);

        // ---- PRESET=0 behaves as 1: flag at E0+3 ----
        bus_write(OFF_PRESET, 32'd0);
        bus_write(OFF_CTRL, 32'h9);
        tick(2);
        check_irq("p0_irq_before", 1'b0);
        tick(1);
        check_irq("p0_irq_rise", 1'b1);
        check_reg("p0_count", OFF_COUNT, 32'd0);

        // ---- reset overrides a same-edge write ----
        reset = 1'b1;
        addr  = OFF_PRESET;
        din   = 32'hDEAD_BEEF;
        we    = 1'b1;
        tick(1);
        we    = 1'b0;
        reset = 1'b0;
        check_irq("rst2_irq", 1'b0);
        check_reg("rst2_ctrl", OFF_CTRL, 32'h0);
        check_reg("rst2_preset", OFF_PRESET, 32'h0);
        check_reg("rst2_count", OFF_COUNT, 32'h0);
        check_reg("rst2_rsvd", OFF_RSVD, 32'h0);

        // ---- read-only COUNT, reserved offset, ignored CTRL upper bits ----
        bus_write(OFF_PRESET, 32'h0000_1234);
        bus_write(OFF_CTRL, 32'hFFFF_FFF8);
        bus_write(OFF_COUNT, 32'h0000_FFFF);
        bus_write(OFF_RSVD, 32'hFFFF_FFFF);
        check_reg("ro_ctrl", OFF_CTRL, 32'h8);
        check_reg("ro_preset", OFF_PRESET, 32'h0000_1234);
        check_reg("ro_count", OFF_COUNT, 32'h0);
        check_reg("ro_rsvd", OFF_RSVD, 32'h0);
        check_irq("ro_irq", 1'b0);

        // ---- randomized trials against the closed-form timing model ----
        // After EN is written at edge E0, with Pm = max(PRESET,1) and
        // N = Pm+3: COUNT = PRESET at E0+2 and drops by one per edge to 0;
        // the flag rises at E0+Pm+2. Auto-reload repeats with period N;
        // one-shot clears EN at E0+Pm+3 and keeps the flag.
        for (int t = 0; t < 8; t++) begin
            reset = 1'b1;
            tick(1);
            reset = 1'b0;

            p         = int'($urandom_range(0, 9));
            mode      = 2'($urandom_range(0, 3));
            im        = 1'($urandom_range(0, 1));
            pm        = (p == 0) ? 1 : p;
            n         = pm + 3;
            auto_mode = (mode == MODE_AUTO);
            ctrl_w    = {im, mode, 1'b1};
            junk_d    = int'($urandom_range(1, 2 * n));

            bus_write(OFF_PRESET, 32'(p));
            bus_write(OFF_CTRL, {28'd0, ctrl_w});

            for (int d = 1; d <= 3 * n; d++) begin
                if (d == junk_d) begin
                    // A write to COUNT or the reserved slot must not disturb anything.
                    bus_write(($urandom_range(0, 1) == 0) ? OFF_COUNT : OFF_RSVD, $urandom);
                end else begin
                    tick(1);
                end

                dp = auto_mode ? (d % n) : d;
                if (dp < 2) begin
                    exp_count = 0;
                end else if (dp - 2 < pm) begin
                    exp_count = p - (dp - 2);
                end else begin
                    exp_count = 0;
                end
                exp_flag = auto_mode ? (dp == pm + 2) : (d >= pm + 2);
                exp_ctrl = (!auto_mode && d >= pm + 3) ? (ctrl_w & 4'hE) : ctrl_w;

                check_irq($sformatf("rnd%0d_d%0d_irq", t, d), im & exp_flag);
                check_reg($sformatf("rnd%0d_d%0d_count", t, d), OFF_COUNT, 32'(exp_count));
                check_reg($sformatf("rnd%0d_d%0d_ctrl", t, d), OFF_CTRL, {28'd0, exp_ctrl});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
